// File: rtl/cache_switch_ctrl.sv
// Cache bank switch controller: writes back the active bank's dirty lines, then commits the new bank.
// Optional perf counters (stall_cycles, wb_count) are built only when CACHE_SWITCH_PERF_EN is defined.
module cache_switch_ctrl #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2,
    parameter int NUM_LINES = 8,
    parameter int LINE_W    = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_switch_cache_w,
    input  logic [BANK_W-1:0] i_switch_target,
    output logic              o_busywait,
    output logic [BANK_W-1:0] o_active_bank,
    output logic [BANK_W-1:0] o_scan_bank,
    output logic [LINE_W-1:0] o_scan_line,
    input  logic              i_line_dirty,
    output logic              o_wb_req,
    input  logic              i_wb_ack,
    output logic              o_clr_dirty,
    output logic              o_switch_done,
    output logic [31:0]       o_stall_cycles,
    output logic [15:0]       o_wb_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WB,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(NUM_LINES - 1);
    localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

    state_t              r_state;
    state_t              w_next_state;
    logic [BANK_W-1:0]   r_active_bank;
    logic [BANK_W-1:0]   w_active_bank_next;
    logic [BANK_W-1:0]   r_target;
    logic [BANK_W-1:0]   w_target_next;
    logic [LINE_W-1:0]   r_scan_line;
    logic [LINE_W-1:0]   w_scan_line_next;
    logic                w_busywait;
    logic                w_wb_req;
    logic                w_clr_dirty;
    logic                w_switch_done;
    logic                w_noop;
    logic                w_last_line;

    // Switching to the current bank or to a nonexistent bank only acknowledges.
    assign w_noop      = ({1'b0, i_switch_target} >= BANK_LIMIT) ||
                         (i_switch_target == r_active_bank);
    assign w_last_line = (r_scan_line == LAST_LINE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_active_bank <= '0;
            r_target      <= '0;
            r_scan_line   <= '0;
        end else begin
            r_state       <= w_next_state;
            r_active_bank <= w_active_bank_next;
            r_target      <= w_target_next;
            r_scan_line   <= w_scan_line_next;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_active_bank_next = r_active_bank;
        w_target_next      = r_target;
        w_scan_line_next   = r_scan_line;
        w_busywait         = 1'b0;
        w_wb_req           = 1'b0;
        w_clr_dirty        = 1'b0;
        w_switch_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_switch_cache_w) begin
                    w_busywait    = 1'b1;
                    w_target_next = i_switch_target;
                    if (w_noop) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_scan_line_next = '0;
                        w_next_state     = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                w_busywait = 1'b1;
                if (i_line_dirty) begin
                    w_next_state = S_WB;
                end else if (w_last_line) begin
                    w_next_state = S_COMMIT;
                end else begin
                    w_scan_line_next = r_scan_line + 1'b1;
                end
            end
            S_WB: begin
                w_busywait = 1'b1;
                w_wb_req   = 1'b1;
                // A reset arriving with the ack must leave the dirty bit untouched.
                if (i_wb_ack) begin
                    w_clr_dirty = ~i_reset;
                    if (w_last_line) begin
                        w_next_state = S_COMMIT;
                    end else begin
                        w_scan_line_next = r_scan_line + 1'b1;
                        w_next_state     = S_SCAN;
                    end
                end
            end
            S_COMMIT: begin
                w_busywait         = 1'b1;
                w_active_bank_next = r_target;
                w_next_state       = S_DONE;
            end
            S_DONE: begin
                w_busywait    = 1'b1;
                w_switch_done = 1'b1;
                w_next_state  = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign o_busywait    = w_busywait;
    assign o_wb_req      = w_wb_req;
    assign o_clr_dirty   = w_clr_dirty;
    assign o_switch_done = w_switch_done;
    assign o_active_bank = r_active_bank;
    assign o_scan_bank   = r_active_bank;
    assign o_scan_line   = r_scan_line;

`ifdef CACHE_SWITCH_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_wb_count;

    // Both counters saturate rather than wrap.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_wb_count     <= '0;
        end else begin
            if (w_busywait && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_clr_dirty && (r_wb_count != '1)) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_wb_count     = r_wb_count;
`else
    assign o_stall_cycles = '0;
    assign o_wb_count     = '0;
`endif

endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Directed self-checking bench for cache_switch_ctrl, built with a 3-bit bank index so that
// out-of-range targets can be driven; a small dirty-bit model and a delayed acker stand in for cache and memory.
module tb_cache_switch_ctrl;

    logic        clock;
    logic        reset;
    logic        switchCacheW;
    logic [2:0]  switchTarget;
    logic        busywait;
    logic [2:0]  activeBank;
    logic [2:0]  scanBank;
    logic [2:0]  scanLine;
    logic        lineDirty;
    logic        wbReq;
    logic        wbAck;
    logic        clrDirty;
    logic        switchDone;
    logic [31:0] stallCycles;
    logic [15:0] wbCount;

    int compareCount = 0;
    int failCount    = 0;

    logic [7:0] setMask [8];
    logic [7:0] clrMask [8];
    int ackDelay = 4;

    int busyTotal   = 0;
    int wbReqTotal  = 0;
    int clrTotal    = 0;
    int doneTotal   = 0;
    int unstable    = 0;
    int ackLines[$];

    int busy0, wbReq0, clr0, done0;

    cache_switch_ctrl #(
        .NUM_BANKS(4),
        .BANK_W   (3),
        .NUM_LINES(8),
        .LINE_W   (3)
    ) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_switch_cache_w(switchCacheW),
        .i_switch_target (switchTarget),
        .o_busywait      (busywait),
        .o_active_bank   (activeBank),
        .o_scan_bank     (scanBank),
        .o_scan_line     (scanLine),
        .i_line_dirty    (lineDirty),
        .o_wb_req        (wbReq),
        .i_wb_ack        (wbAck),
        .o_clr_dirty     (clrDirty),
        .o_switch_done   (switchDone),
        .o_stall_cycles  (stallCycles),
        .o_wb_count      (wbCount)
    );

    assign lineDirty = setMask[scanBank][scanLine] & ~clrMask[scanBank][scanLine];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Memory side: acknowledge a held request after ackDelay waiting cycles.
    initial begin
        int ackWait;
        ackWait = 0;
        wbAck   = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            wbAck = 1'b0;
            if (wbReq) begin
                if (ackWait == ackDelay) begin
                    wbAck   = 1'b1;
                    ackWait = 0;
                end else begin
                    ackWait++;
                end
            end else begin
                ackWait = 0;
            end
        end
    end

    // Observe every cycle at the falling edge and clear dirty bits as the cache would.
    initial begin
        logic       prevWbNoAck;
        logic [2:0] prevLine;
        prevWbNoAck = 1'b0;
        prevLine    = '0;
        for (int b = 0; b < 8; b++) clrMask[b] = '0;
        forever begin
            @(negedge clock);
            if (busywait) busyTotal++;
            if (wbReq) begin
                wbReqTotal++;
                if (prevWbNoAck && (scanLine != prevLine)) unstable++;
                prevWbNoAck = !clrDirty;
                prevLine    = scanLine;
            end else begin
                prevWbNoAck = 1'b0;
            end
            if (clrDirty) begin
                clrTotal++;
                ackLines.push_back(int'(scanLine));
                clrMask[scanBank][scanLine] = 1'b1;
            end
            if (switchDone) doneTotal++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic takeSnapshot();
        busy0  = busyTotal;
        wbReq0 = wbReqTotal;
        clr0   = clrTotal;
        done0  = doneTotal;
    endtask

    // Issue one switch request and wait for the stall to drop.
    task automatic applyStimulus(input logic [2:0] target, input int maxCycles);
        int n;
        takeSnapshot();
        switchCacheW = 1'b1;
        switchTarget = target;
        #1;
        checkOutput("req_cycle_stall", {31'd0, busywait}, 32'd1);
        @(posedge clock);
        #1;
        switchCacheW = 1'b0;
        n = 0;
        while (busywait && (n < maxCycles)) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busywait) checkOutput("switch_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        for (int b = 0; b < 8; b++) setMask[b] = '0;
        reset        = 1'b1;
        switchCacheW = 1'b0;
        switchTarget = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_busywait", {31'd0, busywait}, 32'd0);
        checkOutput("rst_active", {29'd0, activeBank}, 32'd0);
        checkOutput("rst_scan_line", {29'd0, scanLine}, 32'd0);
        checkOutput("rst_wb_req", {31'd0, wbReq}, 32'd0);
        checkOutput("rst_done", {31'd0, switchDone}, 32'd0);
        checkOutput("rst_stall_cnt", stallCycles, 32'd0);
        checkOutput("rst_wb_cnt", {16'd0, wbCount}, 32'd0);
        reset = 1'b0;

        $display("[TB] no-op switch to the active bank");
        applyStimulus(3'd0, 20);
        checkOutput("noop_busy_cycles", busyTotal - busy0, 32'd2);
        checkOutput("noop_done_pulses", doneTotal - done0, 32'd1);
        checkOutput("noop_wb_req", wbReqTotal - wbReq0, 32'd0);
        checkOutput("noop_active", {29'd0, activeBank}, 32'd0);

        $display("[TB] clean bank, switch 0 -> 2");
        applyStimulus(3'd2, 100);
        checkOutput("clean_busy_cycles", busyTotal - busy0, 32'd11);
        checkOutput("clean_wb_req", wbReqTotal - wbReq0, 32'd0);
        checkOutput("clean_done_pulses", doneTotal - done0, 32'd1);
        checkOutput("clean_active", {29'd0, activeBank}, 32'd2);
        checkOutput("clean_last_line", {29'd0, scanLine}, 32'd7);

        $display("[TB] lines 3 and 7 dirty, switch 2 -> 1");
        setMask[2] = 8'b1000_1000;
        ackDelay   = 4;
        applyStimulus(3'd1, 200);
        checkOutput("dirty_busy_cycles", busyTotal - busy0, 32'd21);
        checkOutput("dirty_wb_req_cycles", wbReqTotal - wbReq0, 32'd10);
        checkOutput("dirty_clr_pulses", clrTotal - clr0, 32'd2);
        checkOutput("dirty_ack_count", ackLines.size(), 32'd2);
        if (ackLines.size() >= 2) begin
            checkOutput("dirty_first_line", ackLines[0], 32'd3);
            checkOutput("dirty_second_line", ackLines[1], 32'd7);
        end
        checkOutput("dirty_line_stable", unstable, 32'd0);
        checkOutput("dirty_active", {29'd0, activeBank}, 32'd1);
        checkOutput("dirty_done_pulses", doneTotal - done0, 32'd1);
`ifdef CACHE_SWITCH_PERF_EN
        checkOutput("perf_stall_cycles", stallCycles, 32'd34);
        checkOutput("perf_wb_count", {16'd0, wbCount}, 32'd2);
`else
        checkOutput("perf_stall_off", stallCycles, 32'd0);
        checkOutput("perf_wb_count_off", {16'd0, wbCount}, 32'd0);
`endif

        $display("[TB] reset during writeback of line 5");
        setMask[1] = 8'b0010_0000;
        ackDelay   = 1000;
        takeSnapshot();
        switchCacheW = 1'b1;
        switchTarget = 3'd3;
        @(posedge clock);
        #1;
        switchCacheW = 1'b0;
        n = 0;
        while (!wbReq && (n < 20)) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("abort_reached_wb", {31'd0, wbReq}, 32'd1);
        checkOutput("abort_wb_line", {29'd0, scanLine}, 32'd5);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort_wb_req", {31'd0, wbReq}, 32'd0);
        checkOutput("abort_busywait", {31'd0, busywait}, 32'd0);
        checkOutput("abort_active", {29'd0, activeBank}, 32'd0);
        checkOutput("abort_scan_line", {29'd0, scanLine}, 32'd0);
        checkOutput("abort_no_clr", clrTotal - clr0, 32'd0);
        checkOutput("abort_stall_cnt", stallCycles, 32'd0);
        reset    = 1'b0;
        ackDelay = 4;

        $display("[TB] out-of-range target 5");
        applyStimulus(3'd5, 20);
        checkOutput("range_busy_cycles", busyTotal - busy0, 32'd2);
        checkOutput("range_done_pulses", doneTotal - done0, 32'd1);
        checkOutput("range_wb_req", wbReqTotal - wbReq0, 32'd0);
        checkOutput("range_active", {29'd0, activeBank}, 32'd0);
`ifdef CACHE_SWITCH_PERF_EN
        checkOutput("range_stall_cnt", stallCycles, 32'd2);
`else
        checkOutput("range_stall_off", stallCycles, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/cache_switch_ctrl.md
Name: cache_switch_ctrl

Overview:
- Responder side of the decoder's `switch_cache_w` signal, which the decoder asserts for custom opcode 7'b1111111.
- On a switch request, stalls the pipeline and scans the active cache bank, writing back every dirty line through a request/ack memory handshake.
- Then commits the new active bank, so each context gets its own cache bank.
- Sits between the control/EX stage, the banked data cache and the memory writeback port.

Parameters:
- NUM_BANKS, 4, number of cache banks (context slots)
- BANK_W, 2, width of bank index
- NUM_LINES, 8, lines per bank
- LINE_W, 3, width of line index

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- switch_cache_w  in  1  switch request from control path (level, sampled in IDLE)
- switch_target  in  BANK_W  requested bank index, valid with switch_cache_w
- busywait  out  1  pipeline stall
- active_bank  out  BANK_W  bank currently used by the cache
- scan_bank  out  BANK_W  bank being scanned (equals active_bank)
- scan_line  out  LINE_W  line index presented to cache dirty lookup
- line_dirty  in  1  dirty bit of (scan_bank, scan_line), combinational from cache
- wb_req  out  1  writeback request for (scan_bank, scan_line)
- wb_ack  in  1  memory accepted and completed the writeback this cycle
- clr_dirty  out  1  one-cycle pulse: clear dirty bit of (scan_bank, scan_line)
- switch_done  out  1  one-cycle pulse: switch finished
- stall_cycles  out  32  perf counter (optional feature)
- wb_count  out  16  perf counter (optional feature)

Behaviour:
- Reset values:
  - state=IDLE, active_bank=0, scan_line=0, latched target=0
  - busywait=0, wb_req=0, clr_dirty=0, switch_done=0, counters=0
- Reset mid-operation aborts immediately:
  - no clr_dirty is issued; dirty bits are left as they were
  - active_bank returns to 0
- busywait = (state!=IDLE) | (state==IDLE & switch_cache_w). The stall is combinational in the request cycle.
- IDLE:
  - on switch_cache_w, latch switch_target.
  - if target==active_bank, or target>=NUM_BANKS: go to DONE (no-op, active_bank unchanged).
  - else: scan_line<=0, go to SCAN.
- SCAN, one line per cycle:
  - if line_dirty: go to WB.
  - else if scan_line==NUM_LINES-1: go to COMMIT.
  - else: scan_line<=scan_line+1.
- WB:
  - wb_req=1, held stable with scan_line until wb_ack.
  - in the wb_ack cycle: clr_dirty=1 (combinational); wb_req stays high that cycle.
  - next state: COMMIT if scan_line==NUM_LINES-1, else scan_line+1 and back to SCAN.
  - wb_ack outside WB is ignored.
  - no timeout; WB waits indefinitely.
- COMMIT: active_bank<=latched target; go to DONE.
- DONE:
  - switch_done=1, busywait=1 this cycle; go to IDLE.
  - a fresh switch_cache_w is accepted only in IDLE, and only one cycle after DONE.
- switch_cache_w asserted while not in IDLE is ignored; the pipeline is stalled, so this is a protocol error only.
- Latency:
  - no-op switch: 2 cycles of busywait (request cycle + DONE).
  - real switch: 1 + NUM_LINES + Σ(writeback wait+1 per dirty line) + 1 COMMIT + 1 DONE.
- scan_line wraps only by returning to 0 on the next switch; it never exceeds NUM_LINES-1.

Optional Feature:
- Macro: CACHE_SWITCH_PERF_EN.
- When defined:
  - stall_cycles increments every cycle busywait=1.
  - wb_count increments on each clr_dirty.
  - both saturate at all-ones; reset clears both.
- When undefined: stall_cycles and wb_count are constant 0 and no counter logic is built.

Test Plan:
- Reset, then switch_cache_w=1, target=0 (active=0) -> busywait high for 2 cycles, switch_done pulses once, active_bank stays 0, wb_req never asserted.
- All lines clean, target=2 -> 8 SCAN cycles, scan_line 0..7, no wb_req, COMMIT sets active_bank=2, switch_done one cycle later, total busywait 11 cycles.
- Lines 3 and 7 dirty, wb_ack delayed 4 cycles each, target=1 -> wb_req held with scan_line=3 then 7, clr_dirty pulses exactly twice in the ack cycles, active_bank=1 at end.
- Reset asserted in WB with scan_line=5 -> next cycle state IDLE, wb_req=0, busywait=0, active_bank=0, no clr_dirty.
- target=5 with NUM_BANKS=4 -> treated as no-op: switch_done pulse, active_bank unchanged, no scan.
- CACHE_SWITCH_PERF_EN defined, run the two-dirty-line case -> wb_count=2 and stall_cycles equals the measured busywait cycles; undefined build -> both read 0.
